vga_ctrl: RTL and testbench
===========================

Name: vga_ctrl

Overview:
VGA timing generator plus built-in test-pattern source for a 640x480@60 Hz display, clocked from the 50 MHz system clock.
- Divides the clock by 2 internally to get a 25 MHz pixel enable.
- Runs horizontal and vertical counters and produces registered, active-low hsync/vsync.
- Drives 1-bit-per-channel RGB with eight vertical colour bars during the active area and black during blanking.
- Top-level display leaf with no upstream data interface.

Parameters:
- CLK_DIV, 2, system clocks per pixel.
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch (pixels).
- H_SYNC, 96, hsync pulse width (pixels).
- H_BP, 48, horizontal back porch (pixels); H_TOTAL = 800.
- V_ACTIVE, 480, visible lines.
- V_FP, 10, vertical front porch (lines).
- V_SYNC, 2, vsync pulse width (lines).
- V_BP, 33, vertical back porch (lines); V_TOTAL = 525.
- BAR_W, 80, colour-bar width (pixels).

Ports:
- i_clk  in  1  system clock, 50 MHz, rising edge.
- i_rst_n  in  1  reset; synchronous, active-high (1 = reset) despite the _n suffix.
- o_hsync  out  1  horizontal sync, active low.
- o_vsync  out  1  vertical sync, active low.
- o_analog_r  out  1  red (1 = on).
- o_analog_g  out  1  green.
- o_analog_b  out  1  blue.

Behaviour:
- Single clock domain. Every register samples i_rst_n on the rising edge of i_clk.
- Reset (i_rst_n=1 at an edge):
  - div_cnt=0, h_cnt=0, v_cnt=0.
  - o_hsync=1, o_vsync=1, o_analog_r/g/b=0.
  - Asserting reset mid-frame gives the same result at the next edge; there is no partial-frame state afterwards.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - pix_en = (div_cnt == CLK_DIV-1), combinational.
- Horizontal counter:
  - On an edge with pix_en=1, h_cnt increments.
  - At h_cnt == H_TOTAL-1 it wraps to 0.
- Vertical counter:
  - Increments only on an edge where pix_en=1 and h_cnt wraps.
  - At v_cnt == V_TOTAL-1 it wraps to 0, which starts a new frame.
- Consequence: after the n-th post-reset edge, h_cnt = floor(n/2) mod 800.
- Output stage: all outputs are registered every clock from the pre-edge counter values, i.e. one i_clk of latency relative to the counters.
  - o_hsync = 0 iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751.
  - o_vsync = 0 iff V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, i.e. 490..491. Asserted for whole lines, independent of h_cnt.
  - active = (h_cnt < 640) && (v_cnt < 480).
  - Colour bars: idx = h_cnt / BAR_W (0..7); {r,g,b} = active ? ~idx[2:0] : 3'b000.
  - Bar order: 0 white(111), 1 yellow(110), 2 magenta(101), 3 red(100), 4 cyan(011), 5 green(010), 6 blue(001), 7 black(000).
- Widths:
  - h_cnt 10 bits, v_cnt 10 bits, div_cnt ceil(log2(CLK_DIV)) bits (minimum 1).
  - Compares are unsigned, with no overflow beyond the wrap points.
- Frame period: 800*525*2 = 840000 i_clk cycles. Line period: 1600 cycles.
- Stated in post-reset edges n (edge 1 is the first edge with i_rst_n=0): an output takes the value for h_cnt = floor((n-1)/2).

Test Plan:
- Reset hold: i_rst_n=1 for 5 clocks, then hold for 10 more. Outputs must be hsync=1, vsync=1, rgb=000 throughout, with no counter advance.
- Line timing: release reset and count edges n.
  - rgb=111 from n=1.
  - o_hsync first falls at n=1313 and rises at n=1505.
  - Active-to-black at n=1281.
  - hsync period 1600 clocks, low 192 clocks.
- Colour bars on line 0:
  - rgb=110 at n=161.
  - 101 at n=321.
  - 000 for n=1121..1280 (bar 7).
  - 000 throughout blanking.
- Vertical timing:
  - o_vsync low for exactly 3200 clocks.
  - First vsync fall at n = 490*1600 + 1 = 784001.
  - Frame period 840000 clocks.
  - rgb=000 on all lines with v_cnt >= 480.
- Mid-frame reset: assert i_rst_n=1 for 1 clock at an arbitrary point, e.g. v_cnt=300, h_cnt=700.
  - Next edge: hsync=1, vsync=1, rgb=000.
  - After release, the timing of the second scenario repeats exactly from n=1.
- Wrap check:
  - After 840000 post-reset clocks, the output sequence repeats bit-exactly.
  - No extra line or pixel occurs at either counter wrap.

Source files
------------

// File: rtl/vga_ctrl.sv
// ---------------------------------------------------------------------------
// vga_ctrl
// VGA 640x480@60 Hz timing generator with a built-in eight-bar colour test
// pattern. Runs from the 50 MHz system clock; a divide-by-CLK_DIV counter
// produces the 25 MHz pixel enable that advances the horizontal/vertical
// counters. All outputs are registered one i_clk after the counters.
//
// Ports:
//   i_clk       in   system clock, rising edge
//   i_rst_n     in   synchronous reset, active HIGH (1 = reset) despite name
//   o_hsync     out  horizontal sync, active low
//   o_vsync     out  vertical sync, active low
//   o_analog_r  out  red   (1 = on)
//   o_analog_g  out  green (1 = on)
//   o_analog_b  out  blue  (1 = on)
// ---------------------------------------------------------------------------
module vga_ctrl #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int BAR_W    = 80
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_hsync,
    output logic o_vsync,
    output logic o_analog_r,
    output logic o_analog_g,
    output logic o_analog_b
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] BAR_DIV  = 10'(BAR_W);

    logic [DIV_W-1:0] div_cnt;
    logic [9:0]       h_cnt;
    logic [9:0]       v_cnt;
    logic             pix_en;
    logic             h_wrap;
    logic             v_wrap;

    assign pix_en = (div_cnt == DIV_LAST);
    assign h_wrap = (h_cnt == H_LAST);
    assign v_wrap = (v_cnt == V_LAST);

    // Counters: the line counter only moves on the pixel that ends a line.
    always_ff @(posedge i_clk) begin
        if (i_rst_n) begin
            div_cnt <= '0;
            h_cnt   <= '0;
            v_cnt   <= '0;
        end else begin
            div_cnt <= pix_en ? '0 : div_cnt + DIV_W'(1);
            if (pix_en) begin
                h_cnt <= h_wrap ? 10'd0 : h_cnt + 10'd1;
                if (h_wrap) begin
                    v_cnt <= v_wrap ? 10'd0 : v_cnt + 10'd1;
                end
            end
        end
    end

    logic       hsync_nxt;
    logic       vsync_nxt;
    logic       active;
    logic [2:0] bar_idx;
    logic [2:0] rgb_nxt;

    assign hsync_nxt = !((h_cnt >= HS_START) && (h_cnt < HS_END));
    assign vsync_nxt = !((v_cnt >= VS_START) && (v_cnt < VS_END));
    assign active    = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    // Only meaningful inside the active area, where h_cnt / BAR_W is 0..7.
    assign bar_idx   = 3'(h_cnt / BAR_DIV);
    // Inverting the bar index gives white, yellow, magenta, red, cyan,
    // green, blue, black from left to right.
    assign rgb_nxt   = active ? ~bar_idx : 3'b000;

    always_ff @(posedge i_clk) begin
        if (i_rst_n) begin
            o_hsync    <= 1'b1;
            o_vsync    <= 1'b1;
            o_analog_r <= 1'b0;
            o_analog_g <= 1'b0;
            o_analog_b <= 1'b0;
        end else begin
            o_hsync    <= hsync_nxt;
            o_vsync    <= vsync_nxt;
            o_analog_r <= rgb_nxt[2];
            o_analog_g <= rgb_nxt[1];
            o_analog_b <= rgb_nxt[0];
        end
    end

endmodule

// File: tb/tb_vga_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vga_ctrl
// Directed bench for vga_ctrl. dut_d uses the full 640x480 timing and is
// checked against hand-computed line checkpoints. dut_s keeps the standard
// horizontal timing but a 13-line frame (6 active, FP 2, sync 2, BP 3) so
// vertical sync placement, frame period and frame-wrap repetition fit in a
// short run. Post-reset edge n: outputs reflect h = floor((n-1)/2) mod 800.
// ---------------------------------------------------------------------------
module tb_vga_ctrl;

    logic clk = 1'b0;
    logic rst;

    logic hs_d, vs_d, r_d, g_d, b_d;
    logic hs_s, vs_s, r_s, g_s, b_s;

    vga_ctrl dut_d (
        .i_clk      (clk),
        .i_rst_n    (rst),
        .o_hsync    (hs_d),
        .o_vsync    (vs_d),
        .o_analog_r (r_d),
        .o_analog_g (g_d),
        .o_analog_b (b_d)
    );

    vga_ctrl #(
        .V_ACTIVE (6),
        .V_FP     (2),
        .V_SYNC   (2),
        .V_BP     (3)
    ) dut_s (
        .i_clk      (clk),
        .i_rst_n    (rst),
        .o_hsync    (hs_s),
        .o_vsync    (vs_s),
        .o_analog_r (r_s),
        .o_analog_g (g_s),
        .o_analog_b (b_s)
    );

    always #10 clk = ~clk;

    localparam int NCP     = 20;
    localparam int FRAME_S = 20800;

    int         total = 0;
    int         bad   = 0;
    int         cp_n [NCP];
    logic [4:0] cp_e [NCP];
    logic [4:0] frame_s [FRAME_S];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed={hs,vs,rgb}=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic run_edges(input int n_last, input bit frame);
        int hs_fall1 = 0, hs_fall2 = 0, hs_low = 0;
        int vs_fall1 = 0, vs_fall2 = 0, vs_rise1 = 0, vs_low = 0;
        int blank_err = 0, vs_d_low = 0, wrap_err = 0;
        logic prev_hs = 1'b1, prev_vs = 1'b1;
        logic [4:0] od, os;
        int h, line;
        for (int n = 1; n <= n_last; n++) begin
            step();
            od = {hs_d, vs_d, r_d, g_d, b_d};
            os = {hs_s, vs_s, r_s, g_s, b_s};
            for (int k = 0; k < NCP; k++) begin
                if (cp_n[k] == n) chk($sformatf("line_n%0d", n), od, cp_e[k]);
            end
            if (prev_hs && !hs_d) begin
                if (hs_fall1 == 0) hs_fall1 = n;
                else if (hs_fall2 == 0) hs_fall2 = n;
            end
            if (n <= 1600 && !hs_d) hs_low++;
            prev_hs = hs_d;
            h    = ((n - 1) / 2) % 800;
            line = ((n - 1) / 2) / 800;
            if (h >= 640 && od[2:0] != 3'b000) blank_err++;
            if (frame) begin
                if ((h >= 640 || (line % 13) >= 6) && os[2:0] != 3'b000) blank_err++;
                if (!vs_d) vs_d_low++;
                if (prev_vs && !vs_s) begin
                    if (vs_fall1 == 0) vs_fall1 = n;
                    else if (vs_fall2 == 0) vs_fall2 = n;
                end
                if (!prev_vs && vs_s && vs_rise1 == 0) vs_rise1 = n;
                if (n <= FRAME_S && !vs_s) vs_low++;
                if (n <= FRAME_S) frame_s[n-1] = os;
                else if (n <= 2 * FRAME_S && os !== frame_s[n-FRAME_S-1]) wrap_err++;
                prev_vs = vs_s;
            end
        end
        chk_int("hsync_first_fall", hs_fall1, 1313);
        chk_int("hsync_period", hs_fall2 - hs_fall1, 1600);
        chk_int("hsync_low_clocks", hs_low, 192);
        chk_int("blanking_rgb_errors", blank_err, 0);
        if (frame) begin
            chk_int("vsync_first_fall", vs_fall1, 12801);
            chk_int("vsync_first_rise", vs_rise1, 16001);
            chk_int("vsync_low_clocks", vs_low, 3200);
            chk_int("frame_period", vs_fall2 - vs_fall1, FRAME_S);
            chk_int("full_frame_vsync_low", vs_d_low, 0);
            chk_int("frame_wrap_repeat_errors", wrap_err, 0);
        end
    endtask

    initial begin
        // Line-0 checkpoints on dut_d: {hsync, vsync, r, g, b}
        cp_n = '{1, 160, 161, 320, 321, 481, 641, 801, 961, 1120,
                 1121, 1280, 1281, 1312, 1313, 1504, 1505, 1600, 1601, 2913};
        cp_e = '{5'b11111, 5'b11111, 5'b11110, 5'b11110, 5'b11101,
                 5'b11100, 5'b11011, 5'b11010, 5'b11001, 5'b11001,
                 5'b11000, 5'b11000, 5'b11000, 5'b11000, 5'b01000,
                 5'b01000, 5'b11000, 5'b11000, 5'b11111, 5'b01000};

        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("reset_d", {hs_d, vs_d, r_d, g_d, b_d}, 5'b11000);
            chk("reset_s", {hs_s, vs_s, r_s, g_s, b_s}, 5'b11000);
        end
        for (int i = 0; i < 10; i++) begin
            step();
            chk("reset_hold_d", {hs_d, vs_d, r_d, g_d, b_d}, 5'b11000);
            chk("reset_hold_s", {hs_s, vs_s, r_s, g_s, b_s}, 5'b11000);
        end

        rst = 1'b0;
        // Ends at h=700 on line 33 (dut_s line 7): inside hsync, outside vsync.
        run_edges(54201, 1'b1);
        chk("pre_reset_d", {hs_d, vs_d, r_d, g_d, b_d}, 5'b01000);
        chk("pre_reset_s", {hs_s, vs_s, r_s, g_s, b_s}, 5'b01000);

        rst = 1'b1;
        step();
        chk("mid_reset_d", {hs_d, vs_d, r_d, g_d, b_d}, 5'b11000);
        chk("mid_reset_s", {hs_s, vs_s, r_s, g_s, b_s}, 5'b11000);
        rst = 1'b0;
        run_edges(3300, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
